uart_rx_cfg: RTL and testbench

//  Runtime-configurable UART receiver, successor to the fixed 8N1 receive path of UART.

---
 rtl/uart_rx_cfg_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_rx_cfg.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: FSM state codes, parity mode codes and the
// parity-mode decode helper used by the receive path (and the TX side).
package uart_rx_cfg_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Code 11 is reserved and behaves as "no parity".
    function automatic logic [1:0] par_mode(input logic [1:0] cfg);
        return (cfg == PAR_EVEN || cfg == PAR_ODD) ? cfg : PAR_NONE;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick generator: tick pulses once every final_value+1 clocks.
// Ports: clk, reset (sync, active-high), final_value (divider), tick (1-clk pulse).
module uart_baud_gen #(
    parameter int TIMER_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TIMER_W-1:0] final_value,
    output logic               tick
);

    logic [TIMER_W-1:0] count;

    assign tick = (count == final_value);

    // Wrap on >= so a divider lowered below the current count recovers at once.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (count >= final_value)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..DBIT_MAX data, none/even/odd parity, 1/2 stop).
// Ports: clk, reset, rx, final_value, cfg_dbit/parity/stop in; r_data, r_valid,
// parity_err, frame_err, overrun, break_det out; r_ready in (valid/ready sink).
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16,
    parameter int TIMER_W  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic [TIMER_W-1:0]  final_value,
    input  logic [3:0]          cfg_dbit,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop,
    output logic [DBIT_MAX-1:0] r_data,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                break_det
);

    localparam int         SW     = $clog2(SB_TICK);
    localparam logic [SW-1:0] S_HALF = SW'(SB_TICK / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
    localparam logic [3:0] DMAX   = 4'(DBIT_MAX);

    logic                rx_m, rx_s;
    logic                tick;
    logic [2:0]          state;
    logic [SW-1:0]       s;
    logic [3:0]          n;
    logic [3:0]          dbit;
    logic [1:0]          par;
    logic                stop2;
    logic                stop_cnt;
    logic [DBIT_MAX-1:0] shreg;
    logic                par_bit;
    logic                perr_i;
    logic                ferr_i;

    logic samp_end, first_stop, last_stop;
    logic is_break, complete, ferr_c;

    uart_baud_gen #(.TIMER_W(TIMER_W)) u_baud (
        .clk         (clk),
        .reset       (reset),
        .final_value (final_value),
        .tick        (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign samp_end   = tick && (s == S_LAST);
    assign first_stop = (state == ST_STOP) && samp_end && !stop_cnt;
    assign last_stop  = (state == ST_STOP) && samp_end && (stop_cnt || !stop2);
    // A break is an all-zero frame that also reads 0 at the first stop slot.
    assign is_break   = first_stop && (shreg == '0) && !rx_s
                        && (par == PAR_NONE || !par_bit);
    assign complete   = last_stop && !is_break;
    assign ferr_c     = ferr_i | ~rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            s        <= '0;
            n        <= '0;
            dbit     <= DMAX;
            par      <= PAR_NONE;
            stop2    <= 1'b0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            perr_i   <= 1'b0;
            ferr_i   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s     <= '0;
                        dbit  <= (cfg_dbit < 4'd5 || cfg_dbit > DMAX)
                                 ? DMAX : cfg_dbit;
                        par   <= par_mode(cfg_parity);
                        stop2 <= cfg_stop;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s == S_HALF) begin
                            if (!rx_s) begin
                                state    <= ST_DATA;
                                s        <= '0;
                                n        <= '0;
                                shreg    <= '0;
                                par_bit  <= 1'b0;
                                perr_i   <= 1'b0;
                                ferr_i   <= 1'b0;
                                stop_cnt <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            shreg <= shreg | (DBIT_MAX'(rx_s) << n);
                            if (n == dbit - 4'd1)
                                state <= (par == PAR_NONE) ? ST_STOP : ST_PARITY;
                            else
                                n <= n + 4'd1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s       <= '0;
                            par_bit <= rx_s;
                            // Unused MSBs of shreg are 0, so they do not disturb the XOR.
                            perr_i  <= rx_s ^ (^shreg) ^ (par == PAR_ODD);
                            state   <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (is_break) begin
                                state <= ST_BRK_WAIT;
                            end else if (last_stop) begin
                                state <= ST_IDLE;
                            end else begin
                                stop_cnt <= 1'b1;
                                ferr_i   <= ferr_i | ~rx_s;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_BRK_WAIT: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a completed frame loads only if the slot is free or
    // being drained this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= complete && r_valid && !r_ready;
            break_det <= is_break;
            if (complete && (!r_valid || r_ready)) begin
                r_data     <= shreg;
                parity_err <= perr_i;
                frame_err  <= ferr_c;
                r_valid    <= 1'b1;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int BITCLK = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [10:0] final_value;
    logic [3:0]  cfg_dbit;
    logic [1:0]  cfg_parity;
    logic        cfg_stop;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        break_det;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int brk_cnt  = 0;
    int vrise    = 0;
    logic v_q    = 1'b0;

    typedef struct {
        logic [7:0] word;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    uart_rx_cfg dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .final_value (final_value),
        .cfg_dbit    (cfg_dbit),
        .cfg_parity  (cfg_parity),
        .cfg_stop    (cfg_stop),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (break_det) brk_cnt++;
        if (r_valid && !v_q) vrise++;
        v_q = r_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_bits(input logic [3:0] c);
        return (c < 4'd5 || c > 4'd8) ? 8 : int'(c);
    endfunction

    function automatic logic has_par(input logic [1:0] p);
        return (p == 2'b01 || p == 2'b10);
    endfunction

    function automatic logic [7:0] masked(input logic [7:0] d, input int nb);
        logic [7:0] m;
        m = 8'((1 << nb) - 1);
        return d & m;
    endfunction

    // Parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [7:0] w, input logic [1:0] p);
        int ones;
        ones = $countones(w);
        return (p == 2'b10) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic exp_t model(input logic [7:0] d, input logic [3:0] cd,
                                   input logic [1:0] p, input logic st2,
                                   input logic flip, input logic s0,
                                   input logic s1);
        exp_t e;
        logic pb;
        e.word = masked(d, eff_bits(cd));
        pb     = good_par(e.word, p) ^ flip;
        e.perr = has_par(p) && flip;
        e.ferr = !s0 || (st2 && !s1);
        e.brk  = (e.word == 8'h00) && !s0 && (!has_par(p) || !pb);
        return e;
    endfunction

    task automatic bitt(input logic b);
        rx = b;
        repeat (BITCLK) @(posedge clk);
        #1;
    endtask

    // A low final stop bit is released early so the receiver does not
    // mistake its tail for a new start bit.
    task automatic last_bit(input logic b);
        if (b) begin
            bitt(1'b1);
        end else begin
            rx = 1'b0;
            repeat (48) @(posedge clk);
            #1 rx = 1'b1;
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic flip,
                        input logic s0, input logic s1);
        int nb;
        logic [7:0] w;
        nb = eff_bits(cfg_dbit);
        w  = masked(d, nb);
        bitt(1'b0);
        for (int i = 0; i < nb; i++) bitt(w[i]);
        if (has_par(cfg_parity)) bitt(good_par(w, cfg_parity) ^ flip);
        if (cfg_stop) begin
            bitt(s0);
            last_bit(s1);
        end else begin
            last_bit(s0);
        end
        rx = 1'b1;
    endtask

    task automatic consume();
        @(posedge clk);
        #1 r_ready = 1'b1;
        @(posedge clk);
        #1 r_ready = 1'b0;
    endtask

    task automatic check_word(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(r_valid), 32'd1);
        chk({tag, ".data"}, 32'(r_data), 32'(e.word));
        chk({tag, ".perr"}, 32'(parity_err), 32'(e.perr));
        chk({tag, ".ferr"}, 32'(frame_err), 32'(e.ferr));
    endtask

    initial begin
        exp_t e;
        int o0, b0, v0;
        logic [7:0] d;
        logic flip, s0, s1;

        rx = 1'b1; reset = 1'b1; r_ready = 1'b0; final_value = 11'd3;
        cfg_dbit = 4'd8; cfg_parity = 2'b00; cfg_stop = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.valid", 32'(r_valid), 32'd0);
        chk("rst.data", 32'(r_data), 32'd0);
        chk("rst.perr", 32'(parity_err), 32'd0);
        chk("rst.ferr", 32'(frame_err), 32'd0);
        chk("rst.ovr", 32'(overrun), 32'd0);
        chk("rst.brk", 32'(break_det), 32'd0);

        // 8N1 word held while the consumer stalls
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check_word("t1", model(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        repeat (100) @(posedge clk);
        #1 check_word("t1.hold", model(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        consume();
        chk("t1.drain", 32'(r_valid), 32'd0);

        // 7E1 with good then bad parity
        cfg_dbit = 4'd7; cfg_parity = 2'b01;
        send(8'h55, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check_word("t2a", model(8'h55, 4'd7, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1));
        consume();
        send(8'h55, 1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check_word("t2b", model(8'h55, 4'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1));
        consume();

        // 8N2, second stop bit low
        cfg_dbit = 4'd8; cfg_parity = 2'b00; cfg_stop = 1'b1;
        send(8'h3C, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 check_word("t3", model(8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
        consume();

        // Back-to-back frames while stalled
        cfg_stop = 1'b0;
        o0 = ovr_cnt;
        send(8'h11, 1'b0, 1'b1, 1'b1);
        send(8'h22, 1'b0, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1 check_word("t4", model(8'h11, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        chk("t4.ovr", 32'(ovr_cnt - o0), 32'd1);
        v0 = vrise;
        consume();
        repeat (200) @(posedge clk);
        #1 chk("t4.nodup", 32'(r_valid), 32'd0);
        chk("t4.nonew", 32'(vrise - v0), 32'd0);

        // Short glitch is rejected
        v0 = vrise;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1 chk("t5.glitch", 32'(vrise - v0), 32'd0);

        // Reset in the middle of the data bits
        bitt(1'b0); bitt(1'b1); bitt(1'b0); bitt(1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1; reset = 1'b0;
        repeat (200) @(posedge clk);
        #1 chk("t5.rst", 32'(vrise - v0), 32'd0);
        send(8'h81, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check_word("t5.next", model(8'h81, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        consume();

        // Break: rx low for 12 bit times
        b0 = brk_cnt; v0 = vrise;
        rx = 1'b0;
        repeat (12 * BITCLK) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BITCLK) @(posedge clk);
        #1 chk("t6.brk", 32'(brk_cnt - b0), 32'd1);
        chk("t6.novalid", 32'(vrise - v0), 32'd0);
        send(8'hF0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check_word("t6.next", model(8'hF0, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        consume();

        // Random configurations and frames
        for (int k = 0; k < 12; k++) begin
            d          = 8'($urandom);
            cfg_dbit   = 4'($urandom_range(0, 15));
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop   = 1'($urandom_range(0, 1));
            flip       = 1'($urandom_range(0, 1));
            s0         = ($urandom_range(0, 3) != 0);
            s1         = ($urandom_range(0, 3) != 0);
            if (k % 4 == 3) begin
                d = 8'h00; s0 = 1'b0;
            end
            e  = model(d, cfg_dbit, cfg_parity, cfg_stop, flip, s0, s1);
            b0 = brk_cnt; v0 = vrise;
            send(d, flip, s0, s1);
            repeat (4) @(posedge clk);
            #1;
            if (e.brk) begin
                chk($sformatf("rnd%0d.brk", k), 32'(brk_cnt - b0), 32'd1);
                chk($sformatf("rnd%0d.nov", k), 32'(vrise - v0), 32'd0);
            end else begin
                check_word($sformatf("rnd%0d", k), e);
                chk($sformatf("rnd%0d.nobrk", k), 32'(brk_cnt - b0), 32'd0);
                consume();
            end
            bitt(1'b1);
            bitt(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
